// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instr_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } pf_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_unit_fifo.sv
// Fetch buffer: DEPTH entries of {pc, instr} with push, pop and a flush that wins over both.
module prefetch_fifo
  import instr_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [31:0]              push_pc_i,
  input  logic [31:0]              push_instr_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t          mem_q [DEPTH];
  fetch_entry_t          mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_eff;
  logic                  pop_eff;

  always_comb begin
    push_eff = push_i && !flush_i;
    pop_eff  = pop_i && (count_q != '0) && !flush_i;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = '{pc: push_pc_i, instr: push_instr_i};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The fetch FSM only issues a request when the result will fit, so a full push is a bug upstream.
  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_i && !flush_i && (count_q == CW'(DEPTH))));

  assign valid_o = (count_q != '0);
  assign instr_o = mem_q[rd_ptr_q].instr;
  assign pc_o    = mem_q[rd_ptr_q].pc;
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Prefetch front end: sequential fetch over a req/ack memory port into a small buffer.
//   state | meaning
//   IDLE  | no request outstanding (buffer full or just out of reset)
//   REQ   | request for fetch_pc outstanding, data will be pushed
//   DROP  | request outstanding whose data is discarded after a redirect
module instr_prefetch_unit
  import instr_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_data_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  input  logic                     instr_ready_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_addr_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;

  logic          ack;
  logic          push;
  logic          pop;
  logic [31:0]   redir_pc;
  logic [31:0]   next_pc;
  logic [CW-1:0] count_after;
  logic          space;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_pc_i    (fetch_pc_q),
    .push_instr_i (mem_data_i),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .valid_o      (instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (instr_pc_o),
    .count_o      (count_o)
  );

  always_comb begin
    ack         = mem_ack_i && mem_req_q;
    redir_pc    = redirect_addr_i & ~32'h3;
    next_pc     = fetch_pc_q + PC_INC;
    push        = (state_q == ST_REQ) && ack && !redirect_i;
    pop         = instr_valid_o && instr_ready_i && !redirect_i;
    count_after = redirect_i ? '0 : (count_o + CW'(push) - CW'(pop));
    space       = (count_after < CW'(DEPTH));

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = redir_pc;
        end else if (space) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (ack && redirect_i) begin
          fetch_pc_d = redir_pc;
          mem_addr_d = redir_pc;
        end else if (ack) begin
          fetch_pc_d = next_pc;
          if (space) begin
            mem_addr_d = next_pc;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end else if (redirect_i) begin
          // Request must stay stable until acked; its data is thrown away in DROP.
          fetch_pc_d = redir_pc;
          state_d    = ST_DROP;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
        end
        if (ack) begin
          state_d    = ST_REQ;
          mem_addr_d = redirect_i ? redir_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a controllable single-cycle memory model.
module tb_instr_prefetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic [2:0]  count_o;

  logic auto_ack;
  logic man_ack;
  int   n_chk  = 0;
  int   n_pass = 0;

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .count_o         (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Zero-wait memory acks whenever a request is up; manual mode drives ack directly.
  always_comb begin
    mem_ack_i  = auto_ack ? mem_req_o : man_ack;
    mem_data_i = mem_addr_o ^ XORK;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, want);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
    instr_ready_i = 1'b1; redirect_i = 1'b0; redirect_addr_i = 32'h0;

    // 1: reset state, then zero-wait streaming
    tick();
    chk("rst_req",   32'(mem_req_o), 32'd0);
    chk("rst_addr",  mem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc",    instr_pc_o, 32'h0);
    chk("rst_count", 32'(count_o), 32'd0);
    do_reset();
    tick();
    chk("t1_req1",   32'(mem_req_o), 32'd1);
    chk("t1_addr1",  mem_addr_o, 32'h0);
    chk("t1_valid1", 32'(instr_valid_o), 32'd0);
    tick();
    chk("t1_valid2", 32'(instr_valid_o), 32'd1);
    chk("t1_pc0",    instr_pc_o, 32'h0);
    chk("t1_instr0", instr_o, XORK);
    chk("t1_addr2",  mem_addr_o, 32'h4);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t1_pc",    instr_pc_o, 32'(4 * i));
      chk("t1_instr", instr_o, 32'(4 * i) ^ XORK);
      chk("t1_count", 32'(count_o), 32'd1);
    end

    // 2: backpressure fills the buffer, one pop restarts fetch at 0x10
    instr_ready_i = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("t2_req_full",  32'(mem_req_o), 32'd0);
    chk("t2_count4",    32'(count_o), 32'd4);
    chk("t2_head",      instr_pc_o, 32'h0);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("t2_req_again", 32'(mem_req_o), 32'd1);
    chk("t2_addr10",    mem_addr_o, 32'h10);
    chk("t2_count3",    32'(count_o), 32'd3);
    chk("t2_head4",     instr_pc_o, 32'h4);

    // 3: redirect while 0x8 outstanding, ack arrives 3 cycles later
    do_reset();
    repeat (3) tick();
    auto_ack = 1'b0; man_ack = 1'b0;
    redirect_i = 1'b1; redirect_addr_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    chk("t3_req_hold",  32'(mem_req_o), 32'd1);
    chk("t3_addr_hold", mem_addr_o, 32'h8);
    chk("t3_count0",    32'(count_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_addr_wait",  mem_addr_o, 32'h8);
      chk("t3_valid_wait", 32'(instr_valid_o), 32'd0);
    end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("t3_addr40",  mem_addr_o, 32'h40);
    chk("t3_valid_d", 32'(instr_valid_o), 32'd0);
    auto_ack = 1'b1;
    tick();
    chk("t3_pc40",    instr_pc_o, 32'h40);
    chk("t3_instr40", instr_o, 32'h40 ^ XORK);
    chk("t3_valid",   32'(instr_valid_o), 32'd1);

    // 4: redirect + ack of 0xC + pop in the same cycle
    do_reset();
    repeat (4) tick();
    chk("t4_count3", 32'(count_o), 32'd3);
    chk("t4_addrC",  mem_addr_o, 32'hC);
    auto_ack = 1'b0; man_ack = 1'b1;
    redirect_i = 1'b1; redirect_addr_i = 32'h80; instr_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0; man_ack = 1'b0; auto_ack = 1'b1;
    chk("t4_count0", 32'(count_o), 32'd0);
    chk("t4_valid0", 32'(instr_valid_o), 32'd0);
    chk("t4_addr80", mem_addr_o, 32'h80);
    tick();
    chk("t4_pc80",   instr_pc_o, 32'h80);
    chk("t4_count1", 32'(count_o), 32'd1);

    // 5: unaligned redirect at the top of memory wraps to zero
    do_reset();
    tick();
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    chk("t5_addr_top", mem_addr_o, 32'hFFFF_FFFC);
    chk("t5_count0",   32'(count_o), 32'd0);
    tick();
    chk("t5_addr_wrap", mem_addr_o, 32'h0);
    chk("t5_pc_top",    instr_pc_o, 32'hFFFF_FFFC);
    tick();
    chk("t5_pc_wrap",   instr_pc_o, 32'h0);

    // 6: asynchronous reset mid-request with three buffered entries
    instr_ready_i = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("t6_count3", 32'(count_o), 32'd3);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_req_async",   32'(mem_req_o), 32'd0);
    chk("t6_count_async", 32'(count_o), 32'd0);
    chk("t6_valid_async", 32'(instr_valid_o), 32'd0);
    tick();
    rst_i = 1'b1;
    chk("t6_req_rel", 32'(mem_req_o), 32'd0);
    tick();
    chk("t6_req_after",  32'(mem_req_o), 32'd1);
    chk("t6_addr_reset", mem_addr_o, 32'h0);
    tick();
    chk("t6_pc_reset", instr_pc_o, 32'h0);
    chk("t6_count1",   32'(count_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
